ddr_cmd_sequencer: RTL and testbench
====================================

Name: ddr_cmd_sequencer

Overview:
Host-side command generator that drives the DDR SDRAM device command bus (cke, cs_n, ras_n, cas_n, we_n, addr, ba). It sits directly upstream of the device control logic.
- Runs the power-up init sequence: wait, PRECHARGE ALL, MRS, 2x AUTO_REFRESH.
- Issues periodic refresh.
- Turns single host read/write requests into ACTIVE followed by READ/WRITE with auto-precharge (close-page policy).
- Pulses rd_start/wr_start so the data path can align DQ/DQS.

Parameters:
ROW_WIDTH, 14, row address bits
COL_WIDTH, 10, column address bits (must be <=10; addr[10] carries the auto-precharge flag)
T_INIT, 200, cycles with cke low after reset release
T_RP, 2, precharge-to-next-command cycles
T_MRD, 2, MRS-to-next-command cycles
T_RFC, 8, refresh-to-next-command cycles
T_RCD, 2, ACTIVE-to-READ/WRITE cycles
T_AP, 8, READ/WRITE-AP-to-next-command cycles (burst + tRP)
T_REFI, 780, refresh interval in cycles
MR_BL, 3'b011, burst length code (8)
MR_BT, 1'b0, burst type (sequential)
MR_CL, 3'b010, CAS latency code (2)

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  host request valid
req_ready  out  1  sequencer accepts request this cycle
req_write  in  1  1=write, 0=read
req_addr  in  2+ROW_WIDTH+COL_WIDTH  {ba, row, col}
init_done  out  1  init sequence complete (sticky until reset)
rd_start  out  1  one-cycle pulse coincident with READ command
wr_start  out  1  one-cycle pulse coincident with WRITE command
cke  out  1  clock enable
cs_n  out  1  chip select
ras_n  out  1  command bit
cas_n  out  1  command bit
we_n  out  1  command bit
addr  out  14  address bus
ba  out  2  bank address

Behaviour:
- All command outputs are registered.
- Encodings {cs_n,ras_n,cas_n,we_n}: NOP 0111, ACTIVE 0011, READ 0101, WRITE 0100, PRECHARGE 0010, AUTO_REFRESH 0001, MRS 0000.
- Each command is driven for exactly one cycle; NOP is driven on every other cycle.
- Reset values (applied immediately on rst_n low): cke=0, cs_n/ras_n/cas_n/we_n=1, addr=0, ba=0, req_ready=0, init_done=0, rd_start=wr_start=0. Refresh counter=0, refresh_pending=0.
- States: INIT_WAIT, INIT_PRE, INIT_MRS, INIT_REF1, INIT_REF2, IDLE, ACT, RDWR, REF, WAIT.
  - WAIT uses a down-counter plus a return state; the cycle count includes the command cycle.
- INIT_WAIT: NOP with cke=0 for T_INIT cycles, then cke=1 (held 1 thereafter).
- INIT_PRE: PRECHARGE with addr[10]=1; wait T_RP.
- INIT_MRS: MRS with ba=0 and addr={7'b0,MR_CL,MR_BT,MR_BL}, i.e. 14'h023 at defaults; wait T_MRD.
- INIT_REF1 and INIT_REF2: AUTO_REFRESH each, wait T_RFC after each.
- Entering IDLE sets init_done=1.
- Refresh timer:
  - Counts 0..T_REFI-1 while init_done=1, wrapping at T_REFI-1.
  - On wrap, sets refresh_pending; a wrap while already pending leaves it at 1 (no queueing).
  - refresh_pending clears in the cycle AUTO_REFRESH is driven.
- IDLE:
  - req_ready = (state==IDLE) && init_done && !refresh_pending.
  - refresh_pending has priority: go to REF (AUTO_REFRESH, wait T_RFC, back to IDLE).
  - req_valid && req_ready on an edge: capture req_write and req_addr; req_ready drops next cycle.
- ACT:
  - ACTIVE is driven in the cycle right after the accept edge, with ba=captured ba and addr=row (zero-extended).
  - Then NOP for T_RCD-1 cycles.
- RDWR:
  - READ or WRITE is driven T_RCD cycles after ACTIVE.
  - ba=captured ba; addr[COL_WIDTH-1:0]=col; addr[10]=1; all other addr bits=0.
  - rd_start or wr_start is high in that same cycle.
  - Then wait T_AP and return to IDLE.
- A request accepted at edge E gives ACTIVE in cycle E+1, READ/WRITE in cycle E+1+T_RCD, and req_ready high again at E+1+T_RCD+T_AP (if no refresh is pending).
- A refresh that comes due mid-transaction is served on return to IDLE, before the next request.
- req_valid may drop without a handshake with no effect. req_addr and req_write are ignored except at the accept edge.
- All T_* parameters must be >=1; T_RCD=1 puts READ/WRITE in the cycle right after ACTIVE.
- Reset mid-operation: the captured request is discarded and init restarts from INIT_WAIT after rst_n rises.

Decomposition:
- Package ddr_pkg holds:
  - ddr_cmd_t, a 4-bit enum {cs_n,ras_n,cas_n,we_n} with the CMD_* constants above;
  - seq_state_t;
  - the MRS field layout (BL [2:0], BT [3], CL [6:4]), shared with the device control logic.
- Sub-module ddr_refresh_timer holds the interval counter, refresh_pending, and the clear input.

Test Plan:
- Reset release -> cke=0 for 200 cycles; PRECHARGE with addr[10]=1 at cycle 200; MRS with addr=14'h023 2 cycles later; AUTO_REFRESH at +2 and +8; init_done=1 8 cycles later.
- After init, read req_addr={ba=2,row=14'h1A5,col=10'h03C} accepted at edge E -> ACTIVE ba=2 addr=14'h1A5 at E+1; READ ba=2 addr=14'h043C with rd_start=1 at E+3; req_ready high again at E+11.
- Write request ba=1,row=5,col=8 -> WRITE at E+3 with addr=14'h0408 and wr_start=1, rd_start=0.
- Refresh timer wraps during a transaction with req_valid held -> on return to IDLE, AUTO_REFRESH first; req_ready=0 for 8 cycles; then request accepted.
- Back-to-back requests with req_valid held high -> exactly one ACTIVE per request, spaced T_RCD+T_AP cycles apart; no command overlap.
- rst_n pulsed low between ACTIVE and READ -> outputs go to reset values immediately; no READ issued; full init sequence repeats.

Source files
------------

// File: rtl/ddr_cmd_sequencer_pkg.sv
// Shared DDR command encodings, sequencer states and mode-register field layout.
// Also used by the device control logic, so keep the field positions in sync.
package ddr_pkg;

    localparam int DDR_ADDR_W = 14;
    localparam int DDR_BA_W   = 2;
    localparam int DDR_AP_BIT = 10;

    // Mode register field positions: BL [2:0], BT [3], CL [6:4]
    localparam int MR_BL_LSB = 0;
    localparam int MR_BT_BIT = 3;
    localparam int MR_CL_LSB = 4;

    typedef enum logic [3:0] {
        CMD_MRS          = 4'b0000,
        CMD_AUTO_REFRESH = 4'b0001,
        CMD_PRECHARGE    = 4'b0010,
        CMD_ACTIVE       = 4'b0011,
        CMD_WRITE        = 4'b0100,
        CMD_READ         = 4'b0101,
        CMD_NOP          = 4'b0111
    } ddr_cmd_t;

    typedef enum logic [3:0] {
        INIT_WAIT,
        INIT_PRE,
        INIT_MRS,
        INIT_REF1,
        INIT_REF2,
        IDLE,
        ACT,
        RDWR,
        REF,
        WAIT
    } seq_state_t;

    function automatic logic [DDR_ADDR_W-1:0] mrs_value(input logic [2:0] bl,
                                                        input logic       bt,
                                                        input logic [2:0] cl);
        logic [DDR_ADDR_W-1:0] v;
        v = '0;
        v[MR_BL_LSB +: 3] = bl;
        v[MR_BT_BIT]      = bt;
        v[MR_CL_LSB +: 3] = cl;
        return v;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ddr_cmd_sequencer_if.sv
// Host request handshake plus the DDR device command bus driven by the sequencer.
interface ddr_cmd_sequencer_if
    import ddr_pkg::*;
#(
    parameter int ROW_WIDTH = 14,
    parameter int COL_WIDTH = 10
);
    logic                              req_valid;
    logic                              req_ready;
    logic                              req_write;
    logic [2+ROW_WIDTH+COL_WIDTH-1:0]  req_addr;
    logic                              init_done;
    logic                              rd_start;
    logic                              wr_start;
    logic                              cke;
    logic                              cs_n;
    logic                              ras_n;
    logic                              cas_n;
    logic                              we_n;
    logic [DDR_ADDR_W-1:0]             addr;
    logic [DDR_BA_W-1:0]               ba;

    modport slave (
        input  req_valid, req_write, req_addr,
        output req_ready, init_done, rd_start, wr_start,
               cke, cs_n, ras_n, cas_n, we_n, addr, ba
    );

    modport master (
        output req_valid, req_write, req_addr,
        input  req_ready, init_done, rd_start, wr_start,
               cke, cs_n, ras_n, cas_n, we_n, addr, ba
    );
endinterface

// File: rtl/ddr_cmd_sequencer_refresh_timer.sv
// Free-running refresh interval counter; flags a pending refresh on each wrap.
module ddr_refresh_timer #(
    parameter int T_REFI = 780
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable_i,
    input  logic clear_i,
    output logic pending_o
);
    localparam int CW = $clog2(T_REFI + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          pending_q, pending_d;
    logic          wrap;

    // A wrap while a refresh is still pending does not queue a second one.
    always_comb begin
        wrap      = enable_i && (cnt_q == CW'(T_REFI - 1));
        cnt_d     = cnt_q;
        pending_d = pending_q;
        if (enable_i) begin
            cnt_d = wrap ? '0 : cnt_q + CW'(1);
        end
        if (wrap) begin
            pending_d = 1'b1;
        end else if (clear_i) begin
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            pending_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
        end
    end

    assign pending_o = pending_q;
endmodule

// File: rtl/ddr_cmd_sequencer.sv
// DDR command sequencer: power-up init, periodic refresh, and close-page
// ACTIVE -> READ/WRITE-with-auto-precharge for single host requests.
module ddr_cmd_sequencer
    import ddr_pkg::*;
#(
    parameter int       ROW_WIDTH = 14,
    parameter int       COL_WIDTH = 10,
    parameter int       T_INIT    = 200,
    parameter int       T_RP      = 2,
    parameter int       T_MRD     = 2,
    parameter int       T_RFC     = 8,
    parameter int       T_RCD     = 2,
    parameter int       T_AP      = 8,
    parameter int       T_REFI    = 780,
    parameter logic [2:0] MR_BL   = 3'b011,
    parameter logic       MR_BT   = 1'b0,
    parameter logic [2:0] MR_CL   = 3'b010
) (
    input logic               clk,
    input logic               rst_n,
    ddr_cmd_sequencer_if.slave bus
);
    localparam int T_MAX = max_int(T_INIT, max_int(T_RFC, max_int(T_AP,
                           max_int(T_RP, max_int(T_MRD, T_RCD)))));
    localparam int CNT_W = $clog2(T_MAX + 1);

    seq_state_t              state_q, state_d, ret_q, ret_d, wait_ret;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    int                      wait_len;
    logic                    wait_start;

    logic                    write_q, write_d;
    logic [DDR_BA_W-1:0]     cba_q, cba_d;
    logic [ROW_WIDTH-1:0]    row_q, row_d;
    logic [COL_WIDTH-1:0]    col_q, col_d;

    logic                    init_done_q, init_done_d;
    logic                    refresh_pending;
    logic                    req_ready;
    logic                    accept;

    ddr_cmd_t                cmd_q, cmd_d;
    logic [DDR_ADDR_W-1:0]   addr_q, addr_d;
    logic [DDR_BA_W-1:0]     ba_q, ba_d;
    logic                    cke_q, cke_d;
    logic                    rd_q, rd_d;
    logic                    wr_q, wr_d;

    assign req_ready = (state_q == IDLE) && init_done_q && !refresh_pending;
    assign accept    = req_ready && bus.req_valid;

    ddr_refresh_timer #(
        .T_REFI (T_REFI)
    ) u_refresh_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable_i  (init_done_q),
        .clear_i   (state_d == REF),
        .pending_o (refresh_pending)
    );

    always_comb begin
        write_d = accept ? bus.req_write : write_q;
        cba_d   = accept ? bus.req_addr[2+ROW_WIDTH+COL_WIDTH-1 -: 2] : cba_q;
        row_d   = accept ? bus.req_addr[COL_WIDTH +: ROW_WIDTH] : row_q;
        col_d   = accept ? bus.req_addr[COL_WIDTH-1:0] : col_q;
    end

    // Every command state lasts one cycle; the timing gap to the next command
    // is covered by WAIT, whose count includes the command cycle itself.
    always_comb begin
        state_d    = state_q;
        ret_d      = ret_q;
        cnt_d      = cnt_q;
        wait_start = 1'b0;
        wait_len   = 1;
        wait_ret   = IDLE;
        case (state_q)
            INIT_WAIT: begin
                if (cnt_q == '0) state_d = INIT_PRE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            INIT_PRE:  begin wait_start = 1'b1; wait_len = T_RP;  wait_ret = INIT_MRS;  end
            INIT_MRS:  begin wait_start = 1'b1; wait_len = T_MRD; wait_ret = INIT_REF1; end
            INIT_REF1: begin wait_start = 1'b1; wait_len = T_RFC; wait_ret = INIT_REF2; end
            INIT_REF2: begin wait_start = 1'b1; wait_len = T_RFC; wait_ret = IDLE;      end
            IDLE: begin
                if (refresh_pending) state_d = REF;
                else if (accept)     state_d = ACT;
            end
            ACT:  begin wait_start = 1'b1; wait_len = T_RCD; wait_ret = RDWR; end
            RDWR: begin wait_start = 1'b1; wait_len = T_AP;  wait_ret = IDLE; end
            REF:  begin wait_start = 1'b1; wait_len = T_RFC; wait_ret = IDLE; end
            WAIT: begin
                if (cnt_q == '0) state_d = ret_q;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            default: state_d = INIT_WAIT;
        endcase
        if (wait_start) begin
            if (wait_len <= 1) begin
                state_d = wait_ret;
            end else begin
                state_d = WAIT;
                ret_d   = wait_ret;
                cnt_d   = CNT_W'(wait_len - 2);
            end
        end
    end

    // Command outputs are registered from the state being entered.
    always_comb begin
        cmd_d       = CMD_NOP;
        addr_d      = '0;
        ba_d        = '0;
        rd_d        = 1'b0;
        wr_d        = 1'b0;
        cke_d       = cke_q | (state_d != INIT_WAIT);
        init_done_d = init_done_q | (state_d == IDLE);
        case (state_d)
            INIT_PRE: begin
                cmd_d              = CMD_PRECHARGE;
                addr_d[DDR_AP_BIT] = 1'b1;
            end
            INIT_MRS: begin
                cmd_d  = CMD_MRS;
                addr_d = mrs_value(MR_BL, MR_BT, MR_CL);
            end
            INIT_REF1, INIT_REF2, REF: cmd_d = CMD_AUTO_REFRESH;
            ACT: begin
                cmd_d  = CMD_ACTIVE;
                ba_d   = cba_d;
                addr_d = DDR_ADDR_W'(row_d);
            end
            RDWR: begin
                cmd_d              = write_d ? CMD_WRITE : CMD_READ;
                ba_d               = cba_d;
                addr_d             = DDR_ADDR_W'(col_d);
                addr_d[DDR_AP_BIT] = 1'b1;
                rd_d               = !write_d;
                wr_d               = write_d;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= INIT_WAIT;
            ret_q       <= IDLE;
            cnt_q       <= CNT_W'(T_INIT - 1);
            write_q     <= 1'b0;
            cba_q       <= '0;
            row_q       <= '0;
            col_q       <= '0;
            init_done_q <= 1'b0;
            cmd_q       <= ddr_cmd_t'(4'b1111);
            addr_q      <= '0;
            ba_q        <= '0;
            cke_q       <= 1'b0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            ret_q       <= ret_d;
            cnt_q       <= cnt_d;
            write_q     <= write_d;
            cba_q       <= cba_d;
            row_q       <= row_d;
            col_q       <= col_d;
            init_done_q <= init_done_d;
            cmd_q       <= cmd_d;
            addr_q      <= addr_d;
            ba_q        <= ba_d;
            cke_q       <= cke_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.init_done = init_done_q;
    assign bus.rd_start  = rd_q;
    assign bus.wr_start  = wr_q;
    assign bus.cke       = cke_q;
    assign {bus.cs_n, bus.ras_n, bus.cas_n, bus.we_n} = cmd_q;
    assign bus.addr      = addr_q;
    assign bus.ba        = ba_q;
endmodule

// File: tb/tb_ddr_cmd_sequencer.sv
// Directed bench for ddr_cmd_sequencer: init timing, read/write, back-to-back,
// refresh during a transaction and reset in the middle of a request.
module tb_ddr_cmd_sequencer;

    localparam logic [3:0] C_NOP   = 4'b0111;
    localparam logic [3:0] C_ACT   = 4'b0011;
    localparam logic [3:0] C_READ  = 4'b0101;
    localparam logic [3:0] C_WRITE = 4'b0100;
    localparam logic [3:0] C_PRE   = 4'b0010;
    localparam logic [3:0] C_REF   = 4'b0001;
    localparam logic [3:0] C_MRS   = 4'b0000;
    localparam logic [3:0] C_RST   = 4'b1111;

    logic clk  = 1'b0;
    logic rstN = 1'b0;
    int   cyc;
    int   totalChecks = 0;
    int   badChecks   = 0;
    logic [3:0] cmdBus;

    always #5 clk = ~clk;

    ddr_cmd_sequencer_if bus ();

    ddr_cmd_sequencer dut (
        .clk   (clk),
        .rst_n (rstN),
        .bus   (bus)
    );

    assign cmdBus = {bus.cs_n, bus.ras_n, bus.cas_n, bus.we_n};

    // cyc is the cycle number since reset release; cycle 0 precedes the first edge
    always @(posedge clk or negedge rstN) begin
        if (!rstN) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, cycle=%0d", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        totalChecks++;
        if (actual !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h, wanted 0x%0h",
                     tag, cyc, actual, expected);
        end
    endtask

    task automatic stepTo(input int c);
        int guard;
        guard = 0;
        while (cyc < c && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 5000) checkOutput("step_timeout", cyc, c);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_cmd"},   cmdBus, C_RST);
        checkOutput({tag, "_cke"},   bus.cke, 0);
        checkOutput({tag, "_addr"},  bus.addr, 0);
        checkOutput({tag, "_ba"},    bus.ba, 0);
        checkOutput({tag, "_ready"}, bus.req_ready, 0);
        checkOutput({tag, "_done"},  bus.init_done, 0);
        checkOutput({tag, "_rdwr"},  {bus.rd_start, bus.wr_start}, 0);
    endtask

    task automatic checkInit();
        logic [3:0] expCmd;
        for (int c = 1; c <= 220; c++) begin
            stepTo(c);
            expCmd = C_NOP;
            if (c == 200) expCmd = C_PRE;
            if (c == 202) expCmd = C_MRS;
            if (c == 204 || c == 212) expCmd = C_REF;
            checkOutput("init_cmd", cmdBus, expCmd);
            checkOutput("init_cke", bus.cke, (c >= 200));
            checkOutput("init_done", bus.init_done, (c >= 220));
            if (c == 200) checkOutput("pre_a10", bus.addr[10], 1);
            if (c == 202) begin
                checkOutput("mrs_addr", bus.addr, 14'h023);
                checkOutput("mrs_ba", bus.ba, 0);
            end
        end
        checkOutput("ready_after_init", bus.req_ready, 1);
    endtask

    // Presents a request at the current negedge; returns the accept cycle e.
    task automatic applyStimulus(input bit wr, input logic [1:0] b,
                                 input logic [13:0] row, input logic [9:0] col,
                                 input bit hold, output int e);
        e = cyc;
        checkOutput("ready_at_accept", bus.req_ready, 1);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = {b, row, col};
        stepTo(e + 1);
        bus.req_valid = hold;
        bus.req_write = ~wr;
        bus.req_addr  = ~{b, row, col};
    endtask

    task automatic checkTransaction(input int e, input bit wr, input logic [1:0] expBa,
                                    input logic [13:0] expActAddr,
                                    input logic [13:0] expRwAddr);
        logic [3:0] expCmd;
        for (int c = e + 1; c <= e + 10; c++) begin
            stepTo(c);
            expCmd = C_NOP;
            if (c == e + 1) expCmd = C_ACT;
            if (c == e + 3) expCmd = wr ? C_WRITE : C_READ;
            checkOutput("txn_cmd", cmdBus, expCmd);
            checkOutput("txn_rd_start", bus.rd_start, (c == e + 3) && !wr);
            checkOutput("txn_wr_start", bus.wr_start, (c == e + 3) && wr);
            checkOutput("txn_ready", bus.req_ready, 0);
            if (c == e + 1) begin
                checkOutput("act_addr", bus.addr, expActAddr);
                checkOutput("act_ba", bus.ba, expBa);
            end
            if (c == e + 3) begin
                checkOutput("rw_addr", bus.addr, expRwAddr);
                checkOutput("rw_ba", bus.ba, expBa);
            end
        end
    endtask

    typedef struct {
        bit          wr;
        logic [1:0]  b;
        logic [13:0] row;
        logic [9:0]  col;
        logic [13:0] actAddr;
        logic [13:0] rwAddr;
    } vec_t;

    vec_t b2b [3];

    initial begin
        int e;
        b2b[0] = '{1'b0, 2'd3, 14'h3FFF, 10'h3FF, 14'h3FFF, 14'h07FF};
        b2b[1] = '{1'b1, 2'd0, 14'h0000, 10'h000, 14'h0000, 14'h0400};
        b2b[2] = '{1'b0, 2'd2, 14'h2AAA, 10'h155, 14'h2AAA, 14'h0555};

        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;

        repeat (3) @(negedge clk);
        checkResetValues("reset");
        rstN = 1'b1;
        checkInit();

        stepTo(222);
        applyStimulus(1'b0, 2'd2, 14'h01A5, 10'h03C, 1'b0, e);
        checkTransaction(e, 1'b0, 2'd2, 14'h01A5, 14'h043C);
        stepTo(e + 11);

        applyStimulus(1'b1, 2'd1, 14'h0005, 10'h008, 1'b0, e);
        checkTransaction(e, 1'b1, 2'd1, 14'h0005, 14'h0408);
        stepTo(e + 11);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(b2b[i].wr, b2b[i].b, b2b[i].row, b2b[i].col, 1'b1, e);
            checkTransaction(e, b2b[i].wr, b2b[i].b, b2b[i].actAddr, b2b[i].rwAddr);
            stepTo(e + 11);
        end
        bus.req_valid = 1'b0;
        stepTo(e + 12);
        checkOutput("drop_valid_cmd", cmdBus, C_NOP);
        checkOutput("drop_valid_ready", bus.req_ready, 1);

        // Refresh falls due at cycle 1000, inside this transaction
        stepTo(990);
        applyStimulus(1'b0, 2'd1, 14'h0ABC, 10'h0F0, 1'b1, e);
        checkTransaction(e, 1'b0, 2'd1, 14'h0ABC, 14'h04F0);
        for (int c = 1001; c <= 1009; c++) begin
            stepTo(c);
            checkOutput("refresh_cmd", cmdBus, (c == 1002) ? C_REF : C_NOP);
            checkOutput("refresh_ready", bus.req_ready, 0);
        end
        stepTo(1010);
        applyStimulus(1'b1, 2'd0, 14'h0011, 10'h022, 1'b0, e);
        checkTransaction(e, 1'b1, 2'd0, 14'h0011, 14'h0422);

        stepTo(1025);
        applyStimulus(1'b0, 2'd2, 14'h01A5, 10'h03C, 1'b0, e);
        checkOutput("pre_reset_act", cmdBus, C_ACT);
        #1 rstN = 1'b0;
        #1 checkResetValues("midreset");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("held_reset_cmd", cmdBus, C_RST);
        end
        rstN = 1'b1;
        checkInit();

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end
endmodule
